// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: pre-IF side (valid/pc/inst in, stall out) and
// decode side (valid/pc/inst/ex/ecode out, allowin in).
interface if_stage_if;
  logic        pf_to_fs_valid;
  logic [31:0] pf_pc;
  logic [31:0] inst_sram_rdata;
  logic        fs_stall;

  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_ex;
  logic [5:0]  fs_ecode;

  // Driven by the pre-IF and decode stages around the fetch stage.
  modport master (
    output pf_to_fs_valid,
    output pf_pc,
    output inst_sram_rdata,
    output ds_allowin,
    input  fs_stall,
    input  fs_to_ds_valid,
    input  fs_to_ds_pc,
    input  fs_to_ds_inst,
    input  fs_ex,
    input  fs_ecode
  );

  // Seen from the fetch stage itself.
  modport slave (
    input  pf_to_fs_valid,
    input  pf_pc,
    input  inst_sram_rdata,
    input  ds_allowin,
    output fs_stall,
    output fs_to_ds_valid,
    output fs_to_ds_pc,
    output fs_to_ds_inst,
    output fs_ex,
    output fs_ecode
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: two-entry elastic buffer (OUT + SKID) between the
// pre-IF stage and decode. The stall back to pre-IF is registered, so it lags
// by one cycle; SKID catches the word that arrives during that lag.
// Optional fetch-address fault detection is built when FS_ADEF_EN is defined.
module if_stage (
  input  logic    clk,
  input  logic    reset,
  input  logic    br_taken_cancel,
  input  logic    flush,
  if_stage_if.slave fs
);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
  } entry_t;

  state_e state_q, state_d;
  logic   stall_q, stall_d;
  entry_t out_q, out_d;
  entry_t skid_q;
  entry_t in_word;
  logic   out_load, skid_load;
  logic   cancel, accept, drain, out_valid;

`ifdef FS_ADEF_EN
  localparam logic [31:0] NopInst  = 32'h0340_0000;
  localparam logic [5:0]  EcodeAdef = 6'h08;
`endif

  // Build the incoming entry; a misaligned fetch is turned into a NOP that
  // carries the exception flag down the pipe.
  always_comb begin
    in_word.pc = fs.pf_pc;
`ifdef FS_ADEF_EN
    in_word.ex   = (fs.pf_pc[1:0] != 2'b00);
    in_word.inst = in_word.ex ? NopInst : fs.inst_sram_rdata;
`else
    in_word.ex   = 1'b0;
    in_word.inst = fs.inst_sram_rdata;
`endif
  end

  // Handshake terms; flush and branch cancel both empty the stage, so they
  // collapse into one cancel (flush dominance is implicit).
  always_comb begin
    cancel    = flush | br_taken_cancel;
    out_valid = (state_q != StEmpty) & ~cancel;
    drain     = out_valid & fs.ds_allowin;
    accept    = fs.pf_to_fs_valid & ~stall_q & ~cancel;
  end

  // Next-state and buffer load control.
  always_comb begin
    state_d   = state_q;
    out_load  = 1'b0;
    skid_load = 1'b0;
    out_d     = in_word;
    if (cancel) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d  = StOne;
            out_load = 1'b1;
          end
        end
        StOne: begin
          if (accept && drain) begin
            out_load = 1'b1;
          end else if (accept) begin
            state_d   = StTwo;
            skid_load = 1'b1;
          end else if (drain) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          // stall_q is high in TWO, so no accept can collide with the move.
          if (drain) begin
            state_d  = StOne;
            out_load = 1'b1;
            out_d    = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    stall_d = (state_d == StTwo);
  end

  // State, stall and buffer registers; data is zeroed on reset so the decode
  // outputs read as zero, otherwise only loaded on demand.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      stall_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      if (out_load) begin
        out_q <= out_d;
      end
      if (skid_load) begin
        skid_q <= in_word;
      end
    end
  end

  // Decode-side outputs come straight from OUT; ex is constant zero when the
  // fault detector is not built.
  always_comb begin
    fs.fs_stall       = stall_q;
    fs.fs_to_ds_valid = out_valid;
    fs.fs_to_ds_pc    = out_q.pc;
    fs.fs_to_ds_inst  = out_q.inst;
    fs.fs_ex          = out_q.ex;
`ifdef FS_ADEF_EN
    fs.fs_ecode = out_q.ex ? EcodeAdef : 6'h00;
`else
    fs.fs_ecode = 6'h00;
`endif
  end

  // The registered stall must always mirror the TWO state.
  a_stall_two : assert property (@(posedge clk) disable iff (reset)
    stall_q == (state_q == StTwo));

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have input clk, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have input reset, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have input pf_to_fs_valid, 1 bit: the pre-IF stage holds a valid fetch PC this cycle.
REQ-004 SHALL have input pf_pc, 32 bits: fetch PC registered in the pre-IF stage.
REQ-005 SHALL have input inst_sram_rdata, 32 bits: instruction word for pf_pc, valid in the same cycle as pf_pc.
REQ-006 SHALL have input ds_allowin, 1 bit: the decode stage accepts a word this cycle.
REQ-007 SHALL have input br_taken_cancel, 1 bit: a taken branch resolved; younger fetches are wrong-path.
REQ-008 SHALL have input flush, 1 bit: exception or return redirect; highest-priority cancel.
REQ-009 SHALL have output fs_stall, 1 bit: pre-IF stall request; driven only from a register.
REQ-010 SHALL have output fs_to_ds_valid, 1 bit: decode-side word valid.
REQ-011 SHALL have outputs fs_to_ds_pc and fs_to_ds_inst, 32 bits each: decode-side PC and instruction.
REQ-012 SHALL have output fs_ex (1 bit) and fs_ecode (6 bits): fetch exception flag and code.

Function
REQ-013 SHALL implement a 2-entry elastic buffer: an output register (OUT) plus a skid register (SKID), each holding {pc, inst, ex}.
REQ-014 SHALL use FSM states EMPTY (both free), ONE (OUT valid), and TWO (OUT and SKID valid).
REQ-015 SHALL define accept = pf_to_fs_valid & !fs_stall & !br_taken_cancel & !flush.
REQ-016 SHALL define drain = fs_to_ds_valid & ds_allowin.
REQ-017 SHALL make these EMPTY transitions: accept -> ONE, capturing into OUT.
REQ-018 SHALL make these ONE transitions:
- accept & drain -> ONE, with OUT reloaded.
- accept & !drain -> TWO, capturing into SKID.
- !accept & drain -> EMPTY.
REQ-019 SHALL make these TWO transitions: drain -> ONE, with SKID moved to OUT; no accept is possible in TWO.
REQ-020 SHALL register fs_stall as 1 exactly when the next state is TWO.
REQ-021 SHALL make the pre-IF stall lag by one cycle; SKID absorbs the word arriving in that cycle.
REQ-022 SHALL drive fs_to_ds_valid = (state != EMPTY) & !flush & !br_taken_cancel.
REQ-023 SHALL drive fs_to_ds_pc, fs_to_ds_inst and fs_ex from OUT.
REQ-024 SHALL have zero-bubble latency: a word accepted in cycle N is presented to decode in cycle N+1.
REQ-025 SHALL sustain a throughput of 1 word/cycle while ds_allowin = 1.
REQ-026 SHALL, on flush or br_taken_cancel, move to EMPTY next cycle, discard OUT and SKID, clear fs_stall, and ignore pf_to_fs_valid that cycle.
REQ-027 SHALL give flush priority over br_taken_cancel; both asserted behaves as flush.
REQ-028 SHALL, on cancel asserted in the same cycle as drain, suppress the drain (decode sees valid = 0).
REQ-029 SHALL preserve ordering: the OUT word always precedes the SKID word, and no word is duplicated or dropped absent cancel.
REQ-030 SHALL hold OUT/SKID contents in data registers that are don't-care when the state marks them invalid.

Reset
REQ-031 SHALL, on reset, set state EMPTY, fs_stall = 0, fs_to_ds_valid = 0, fs_to_ds_pc = 0, fs_to_ds_inst = 0, fs_ex = 0, fs_ecode = 0.
REQ-032 SHALL give reset priority over flush, cancel and accept.
REQ-033 SHALL, on reset mid-operation with state TWO, discard both entries.

Configuration
REQ-034 SHALL provide fetch-address fault detection, included only with macro FS_ADEF_EN defined.
REQ-035 SHALL, with FS_ADEF_EN defined, mark an accepted word ex = 1 when pf_pc[1:0] != 0.
REQ-036 SHALL, for such a faulting word, replace its inst with NOP 32'h03400000.
REQ-037 SHALL, with FS_ADEF_EN defined, drive fs_ecode = 6'h08 whenever fs_ex = 1, else 0.
REQ-038 SHALL, without FS_ADEF_EN, tie fs_ex = 0 and fs_ecode = 0 and pass inst unmodified.

Verification
REQ-039 SHALL cover streaming: pf_pc 0x1c000000, 04, 08, all valid, ds_allowin = 1 -> the same three PCs appear on decode in cycles N+1..N+3, fs_stall always 0.
REQ-040 SHALL cover backpressure: ds_allowin = 0 for 3 cycles during streaming -> state TWO, fs_stall = 1 from the following cycle, no PC lost or duplicated after release.
REQ-041 SHALL cover cancel in TWO: br_taken_cancel = 1 while in TWO -> next cycle fs_to_ds_valid = 0 and fs_stall = 0, then pf_pc = br_target is delivered next.
REQ-042 SHALL cover simultaneous cancels: flush and br_taken_cancel both 1 while drain would occur -> decode sees valid = 0 and state EMPTY.
REQ-043 SHALL cover the fault case with FS_ADEF_EN: pf_pc = 0x1c000002 -> fs_ex = 1, fs_ecode = 0x08, fs_to_ds_inst = 0x03400000; without the macro, fs_ex = 0 and the raw inst is passed.
REQ-044 SHALL cover reset: reset asserted in state TWO -> all outputs are reset values next cycle, and the first post-reset accept lands in OUT.
